// File: rtl/trap_seq_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus bit positions, FSM state encoding and trap-kind encoding.
package trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_MTI     = 7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_REDIRECT = 3'd4
  } state_t;

  // Same ordering as the ExceptType_* codes used by CTRL.
  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_TIMER = 2'd1,
    KIND_ECALL = 2'd2,
    KIND_MRET  = 2'd3
  } trap_kind_t;

  function automatic logic is_interrupt(input trap_kind_t kind);
    return kind == KIND_TIMER;
  endfunction

endpackage

// File: rtl/trap_seq_status_upd.sv
// mstatus next-value calculator for trap entry and mret.
// Latency: combinational. Backpressure: none.
// Only MIE/MPIE/MPP change; every other bit passes through.
module trap_seq_status_upd
  import trap_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] cur_status,
  input  logic            is_mret,
  output logic [XLEN-1:0] next_status
);

  always_comb begin
    next_status = cur_status;
    if (is_mret) begin
      next_status[MSTATUS_MIE]                   = cur_status[MSTATUS_MPIE];
      next_status[MSTATUS_MPIE]                  = 1'b1;
      next_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    end else begin
      next_status[MSTATUS_MPIE]                  = cur_status[MSTATUS_MIE];
      next_status[MSTATUS_MIE]                   = 1'b0;
      next_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
  end

endmodule

// File: rtl/trap_seq.sv
// Trap sequencer: ecall/timer/mret as serial mepc, mcause, mstatus writes, then a redirect pulse.
// Latency: trap writes T+1..T+3, redirect T+4; mret write T+1, redirect T+2.
// Backpressure: stall_o holds the pipeline from the accept cycle until IDLE; events while busy are dropped.
// Optional TRAP_SEQ_VECTORED_EN enables vectored mtvec mode for interrupts.
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid_i,
  input  logic              except_ecall_i,
  input  logic              except_mret_i,
  input  logic              timer_pending_i,
  input  logic              mie_mtie_i,
  input  logic [XLEN-1:0]   exceptpc_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [XLEN-1:0]   mstatus_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              stall_o,
  output logic              trap_flag_o,
  output logic [XLEN-1:0]   trap_dnpc_o,
  output logic              busy_o
);

  localparam logic [XLEN-1:0] CAUSE_TIMER_VAL = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(CAUSE_MTI);
  localparam logic [XLEN-1:0] CAUSE_ECALL_VAL = XLEN'(CAUSE_ECALL_M);

  state_t          state_q, state_d;
  trap_kind_t      kind_q, acc_kind;
  logic [XLEN-1:0] pc_q, tvec_q, epc_q, status_q;
  logic [XLEN-1:0] status_nxt, trap_base, trap_target;
  logic            tint, accept;

  assign tint = timer_pending_i & mie_mtie_i & mstatus_i[MSTATUS_MIE];

  always_comb begin
    acc_kind = KIND_NONE;
    if (tint)                acc_kind = KIND_TIMER;
    else if (except_ecall_i) acc_kind = KIND_ECALL;
    else if (except_mret_i)  acc_kind = KIND_MRET;
  end

  assign accept  = (state_q == ST_IDLE) & instr_valid_i & (acc_kind != KIND_NONE);
  assign busy_o  = (state_q != ST_IDLE);
  assign stall_o = busy_o | accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_NONE;
      pc_q     <= '0;
      tvec_q   <= '0;
      epc_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q   <= acc_kind;
        pc_q     <= exceptpc_i;
        tvec_q   <= mtvec_i;
        epc_q    <= mepc_i;
        status_q <= mstatus_i;
      end
    end
  end

  trap_seq_status_upd #(.XLEN(XLEN)) u_status_upd (
    .cur_status  (status_q),
    .is_mret     (kind_q == KIND_MRET),
    .next_status (status_nxt)
  );

  assign trap_base = {tvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_SEQ_VECTORED_EN
  // Vectored mode offsets interrupts by 4*cause; exceptions always land on the base.
  assign trap_target = (tvec_q[1:0] == 2'b01 && is_interrupt(kind_q))
                       ? trap_base + XLEN'(4 * CAUSE_MTI) : trap_base;
`else
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^tvec_q[1:0];
  assign trap_target      = trap_base;
`endif

  always_comb begin
    state_d     = state_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    trap_flag_o = 1'b0;
    trap_dnpc_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (acc_kind == KIND_MRET) ? ST_W_STATUS : ST_W_EPC;
      end
      ST_W_EPC: begin
        state_d     = ST_W_CAUSE;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CSR_MEPC);
        csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
      end
      ST_W_CAUSE: begin
        state_d     = ST_W_STATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CSR_MCAUSE);
        csr_wdata_o = (kind_q == KIND_TIMER) ? CAUSE_TIMER_VAL : CAUSE_ECALL_VAL;
      end
      ST_W_STATUS: begin
        state_d     = ST_REDIRECT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o = status_nxt;
      end
      ST_REDIRECT: begin
        state_d     = ST_IDLE;
        trap_flag_o = 1'b1;
        trap_dnpc_o = (kind_q == KIND_MRET) ? epc_q : trap_target;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: vector table of single events plus reset and back-to-back sequences.
// Expected values are hand-computed; vectored target follows TRAP_SEQ_VECTORED_EN.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_i = 1'b0, except_ecall_i = 1'b0, except_mret_i = 1'b0;
  logic        timer_pending_i = 1'b0, mie_mtie_i = 1'b0;
  logic [63:0] exceptpc_i = '0, mtvec_i = '0, mepc_i = '0, mstatus_i = '0;
  logic        csr_we_o, stall_o, trap_flag_o, busy_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o, trap_dnpc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_idx  = -1;

  always #5 clk = ~clk;

  trap_seq #(.XLEN(64), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid_i), .except_ecall_i(except_ecall_i),
    .except_mret_i(except_mret_i), .timer_pending_i(timer_pending_i),
    .mie_mtie_i(mie_mtie_i), .exceptpc_i(exceptpc_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .trap_flag_o(trap_flag_o), .trap_dnpc_o(trap_dnpc_o),
    .busy_o(busy_o)
  );

  // kind: 0 = not accepted, 1 = trap (3 writes), 2 = mret (1 write)
  typedef struct {
    logic        vld, ecall, mret, tpend, mtie;
    logic [63:0] pc, mtvec, mepc, mstatus;
    int          kind;
    logic [63:0] exp_epc, exp_cause, exp_status, exp_dnpc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, cur_idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_valid_i = 0; except_ecall_i = 0; except_mret_i = 0;
    timer_pending_i = 0; mie_mtie_i = 0;
    exceptpc_i = '0; mtvec_i = '0; mepc_i = '0; mstatus_i = '0;
  endtask

  task automatic drive(input vec_t v);
    instr_valid_i = v.vld; except_ecall_i = v.ecall; except_mret_i = v.mret;
    timer_pending_i = v.tpend; mie_mtie_i = v.mtie;
    exceptpc_i = v.pc; mtvec_i = v.mtvec; mepc_i = v.mepc; mstatus_i = v.mstatus;
  endtask

  task automatic chk_write(input string name, input logic [11:0] addr, input logic [63:0] data);
    chk({name, "_we"}, 64'(csr_we_o), 64'd1);
    chk({name, "_addr"}, 64'(csr_waddr_o), 64'(addr));
    chk({name, "_data"}, csr_wdata_o, data);
    chk({name, "_stall"}, 64'(stall_o), 64'd1);
    chk({name, "_flag"}, 64'(trap_flag_o), 64'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_stall"}, 64'(stall_o), 64'd0);
    chk({name, "_we"}, 64'(csr_we_o), 64'd0);
    chk({name, "_flag"}, 64'(trap_flag_o), 64'd0);
    chk({name, "_dnpc"}, trap_dnpc_o, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    chk("acc_stall", 64'(stall_o), 64'(v.kind != 0));
    chk("acc_busy", 64'(busy_o), 64'd0);
    chk("acc_we", 64'(csr_we_o), 64'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    if (v.kind == 0) begin
      chk_idle("noacc");
    end else begin
      if (v.kind == 1) begin
        chk_write("w_epc", 12'h341, v.exp_epc);
        @(negedge clk);
        chk_write("w_cause", 12'h342, v.exp_cause);
        @(negedge clk);
      end
      chk_write("w_status", 12'h300, v.exp_status);
      @(negedge clk);
      chk("redir_flag", 64'(trap_flag_o), 64'd1);
      chk("redir_dnpc", trap_dnpc_o, v.exp_dnpc);
      chk("redir_we", 64'(csr_we_o), 64'd0);
      chk("redir_busy", 64'(busy_o), 64'd1);
      @(negedge clk);
      chk_idle("done");
    end
  endtask

  localparam logic [63:0] TCAUSE = 64'h8000_0000_0000_0007;
  localparam logic [63:0] VEC_TIMER_DNPC =
`ifdef TRAP_SEQ_VECTORED_EN
    64'h8000_101C;
`else
    64'h8000_1000;
`endif

  initial begin
    //           vld ecall mret tpend mtie pc                mtvec          mepc                   mstatus                kind epc            cause   status                 dnpc
    vecs[0]  = '{1, 1, 0, 0, 0, 64'h8000_0104, 64'h8000_1000, 64'h0,                 64'h8,                 1, 64'h8000_0104, 64'd11, 64'h1880,                64'h8000_1000};
    vecs[1]  = '{1, 0, 1, 0, 0, 64'h8000_0050, 64'h8000_1000, 64'h8000_0108,         64'h1880,              2, 64'h0,         64'h0,  64'h88,                  64'h8000_0108};
    vecs[2]  = '{1, 1, 0, 1, 1, 64'h8000_0200, 64'h8000_1000, 64'h0,                 64'h8,                 1, 64'h8000_0200, TCAUSE, 64'h1880,                64'h8000_1000};
    vecs[3]  = '{1, 0, 0, 1, 1, 64'h8000_0300, 64'h8000_1000, 64'h0,                 64'h0,                 0, 64'h0,         64'h0,  64'h0,                   64'h0};
    vecs[4]  = '{1, 0, 0, 1, 1, 64'h8000_0300, 64'h8000_1000, 64'h0,                 64'h8,                 1, 64'h8000_0300, TCAUSE, 64'h1880,                64'h8000_1000};
    vecs[5]  = '{1, 1, 0, 0, 0, 64'h8000_0107, 64'h8000_2000, 64'h0,                 64'hA000_0000_0000_0080, 1, 64'h8000_0104, 64'd11, 64'hA000_0000_0000_1800, 64'h8000_2000};
    vecs[6]  = '{1, 1, 1, 0, 0, 64'h8000_0400, 64'h8000_1003, 64'h8000_0999,         64'h8,                 1, 64'h8000_0400, 64'd11, 64'h1880,                64'h8000_1000};
    vecs[7]  = '{0, 1, 0, 1, 1, 64'h8000_0500, 64'h8000_1000, 64'h0,                 64'h8,                 0, 64'h0,         64'h0,  64'h0,                   64'h0};
    vecs[8]  = '{1, 0, 0, 1, 1, 64'h8000_0600, 64'h8000_1001, 64'h0,                 64'h8,                 1, 64'h8000_0600, TCAUSE, 64'h1880,                VEC_TIMER_DNPC};
    vecs[9]  = '{1, 1, 0, 0, 0, 64'h8000_0700, 64'h8000_1001, 64'h0,                 64'h8,                 1, 64'h8000_0700, 64'd11, 64'h1880,                64'h8000_1000};
    vecs[10] = '{1, 0, 1, 0, 0, 64'h8000_0800, 64'h8000_1000, 64'h1234_5678_9ABC_DEF0, 64'h1808,            2, 64'h0,         64'h0,  64'h80,                  64'h1234_5678_9ABC_DEF0};
    vecs[11] = '{1, 0, 0, 1, 0, 64'h8000_0900, 64'h8000_1000, 64'h0,                 64'h8,                 0, 64'h0,         64'h0,  64'h0,                   64'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_addr", 64'(csr_waddr_o), 64'd0);
    chk("reset_data", csr_wdata_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      cur_idx = i;
      run_vec(vecs[i]);
    end

    // Timer blocked by MIE=0, then accepted once MIE is set
    cur_idx = 100;
    @(posedge clk); #1;
    instr_valid_i = 1; timer_pending_i = 1; mie_mtie_i = 1;
    exceptpc_i = 64'h8000_0A00; mtvec_i = 64'h8000_1000; mstatus_i = 64'h0;
    @(negedge clk);
    chk("mie0_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    chk("mie0_busy", 64'(busy_o), 64'd0);
    mstatus_i = 64'h8;
    @(negedge clk);
    chk("mie1_stall", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk_write("mie1_epc", 12'h341, 64'h8000_0A00);
    @(negedge clk);
    chk_write("mie1_cause", 12'h342, TCAUSE);
    repeat (3) @(negedge clk);
    chk_idle("mie1_done");

    // Reset in the middle of an ecall sequence, then a clean rerun
    cur_idx = 101;
    @(posedge clk); #1;
    drive(vecs[0]);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    chk("mid_addr", 64'(csr_waddr_o), 64'h342);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", csr_wdata_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cur_idx = 0;
    run_vec(vecs[0]);

    // Held mret: ignored while busy, re-accepted in the cycle IDLE is re-entered
    cur_idx = 102;
    @(posedge clk); #1;
    drive(vecs[1]);
    @(negedge clk);
    chk("b2b_acc", 64'(stall_o), 64'd1);
    @(negedge clk);
    chk_write("b2b_status", 12'h300, 64'h88);
    @(negedge clk);
    chk("b2b_flag", 64'(trap_flag_o), 64'd1);
    chk("b2b_dnpc", trap_dnpc_o, 64'h8000_0108);
    @(negedge clk);
    chk("b2b_busy", 64'(busy_o), 64'd0);
    chk("b2b_reacc", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk_write("b2b_status2", 12'h300, 64'h88);
    repeat (2) @(negedge clk);
    chk_idle("b2b_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Multi-cycle trap sequencer that sits between the trap-decision logic in CTRL and the CSR file / IFU.
- On ecall, timer interrupt or mret, it stalls the pipeline and performs the machine-mode CSR side effects as a fixed sequence of single CSR writes: mepc, mcause, mstatus.
- It then issues one redirect pulse carrying the trap target PC and a pipeline flush.
- It replaces the combinational single-cycle trap path with a single-write-port CSR sequence.

Parameters:
- XLEN, 64, data/PC width (matches `DataBus_WIDTH).
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- instr_valid_i  in  1  instruction at commit point is valid; gates event acceptance
- except_ecall_i  in  1  committing instruction is ecall
- except_mret_i  in  1  committing instruction is mret
- timer_pending_i  in  1  level timer interrupt request (mip.MTIP)
- mie_mtie_i  in  1  mie.MTIE
- exceptpc_i  in  XLEN  PC of committing instruction
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- mstatus_i  in  XLEN  current mstatus
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  CSR_AW  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- stall_o  out  1  hold IFU/IDU/EXU
- trap_flag_o  out  1  one-cycle redirect pulse to IFU; also flush
- trap_dnpc_o  out  XLEN  redirect target, valid when trap_flag_o=1
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: state=IDLE; all registered state zero. Outputs while in IDLE with no acceptance: csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, trap_flag_o=0, trap_dnpc_o=0, stall_o=0, busy_o=0.
- Reset asserted mid-sequence aborts the sequence immediately. Partially written CSRs are not rolled back.
- Interrupt eligibility: tint = timer_pending_i & mie_mtie_i & mstatus_i[3] (MIE).
- Acceptance happens only in IDLE when instr_valid_i=1 and (tint | ecall | mret).
  - Priority: timer > ecall > mret.
  - On acceptance, latch kind, exceptpc_i, mtvec_i, mepc_i and mstatus_i.
  - Timer with a simultaneous ecall: take the timer; mepc = that PC; the ecall re-executes after return.
- stall_o = busy_o | accept. It is combinational in the accept cycle so the committing instruction is held.
- Events arriving while busy_o=1 are ignored. timer_pending_i is level-sensitive and is re-sampled in IDLE.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
  - Trap path: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE.
  - mret path: IDLE -> W_STATUS -> REDIRECT -> IDLE.
- W_EPC: we=1, addr=0x341, data=latched pc with bits [1:0] cleared.
- W_CAUSE: we=1, addr=0x342. data = 11 for ecall; data = (1<<(XLEN-1)) | 7 for timer.
- W_STATUS: we=1, addr=0x300. All other mstatus bits are unchanged.
  - Trap: MPIE(bit 7) <= MIE; MIE(bit 3) <= 0; MPP[12:11] <= 2'b11.
  - mret: MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
- REDIRECT: trap_flag_o=1 for exactly one cycle; we=0.
  - trap_dnpc_o = {mtvec[XLEN-1:2], 2'b00} for traps.
  - trap_dnpc_o = latched mepc for mret.
- Latency from accept cycle T: trap CSR writes at T+1, T+2, T+3; redirect at T+4. mret: write at T+1; redirect at T+2.
- IDLE is entered at T+5 (trap) or T+3 (mret). A back-to-back event may be accepted in that cycle.
- Exactly one CSR write per cycle. The CSR file must not take other software writes while busy_o=1.

Optional Feature:
- Macro: TRAP_SEQ_VECTORED_EN.
- Defined: when mtvec_i[1:0]==2'b01 and the trap is an interrupt, trap_dnpc_o = base + 4*cause_code. Timer: base + 28. Exceptions always go to base.
- Undefined: mtvec_i[1:0] is ignored; all traps go to base (direct mode only).

Decomposition:
- Shared package/defines (extend defines.v):
  - CSR addresses MSTATUS=0x300, MEPC=0x341, MCAUSE=0x342.
  - Cause codes ECALL_M=11, MTI=7.
  - mstatus bit positions MIE, MPIE, MPP.
  - FSM state encoding.
  - trap-kind enum (NONE/TIMER/ECALL/MRET), aligned with `ExceptType_*.
- One natural sub-module: trap_seq_status_upd, a combinational mstatus next-value calculator for the trap/mret cases.

Test Plan:
- ecall at pc=0x8000_0104, mtvec=0x8000_1000, mstatus=0x8 -> writes 0x341=0x8000_0104, 0x342=11, 0x300=0x1880 on T+1..T+3; trap_flag at T+4 with dnpc=0x8000_1000; stall high T..T+4.
- mret with mepc=0x8000_0108, mstatus=0x1880 -> 0x300=0x88 at T+1; trap_flag at T+2 with dnpc=0x8000_0108.
- timer_pending=1, MTIE=1, MIE=1, simultaneous ecall, pc=0x8000_0200 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0200.
- timer_pending=1 with MIE=0 -> no acceptance, stall_o=0. Set MIE=1 -> accepted the next valid cycle.
- rst asserted at T+2 of an ecall sequence -> all outputs 0 immediately; the next ecall runs the full sequence.
- With TRAP_SEQ_VECTORED_EN and mtvec=0x8000_1001, timer trap -> dnpc=0x8000_101C. ecall under the same mtvec -> dnpc=0x8000_1000.
